system_top: RTL and testbench
=============================

Name: system_top

Overview:
- SPI-slave front end wrapped around a single-precision floating-point ALU.
- An SPI master sends a 64-bit frame carrying two IEEE-754 operands. At end of frame the block computes the operation selected by the opcode pins.
- The 64-bit frame shifted out during the next transaction carries a status word and the result.
- Top level of the FPGA ALU demo; all logic runs on sys_clock, and SPI pins are treated as asynchronous inputs.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single; fixed).
- FRAME_W, 64, SPI frame length in bits (2*DATA_W).
- SYNC_STAGES, 2, synchronizer depth for SPI_CLK, SPI_CS, SPI_PICO.

Ports:
- sys_clock  in  1  system clock (100 MHz nominal).
- reset  in  1  asynchronous, active-low reset.
- SPI_CLK  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0); must be at most sys_clock/8.
- SPI_CS  in  1  active-low chip select; frame boundary.
- SPI_PICO  in  1  serial data in, MSB first.
- SPI_POCI  out  1  serial data out, MSB first; always driven (no tristate).
- opcode1  in  1  operation select bit 0.
- opcode2  in  1  operation select bit 1.
- opcode3  in  1  reserved; ignored.

Behaviour:
- Reset asserted (reset=0), all asynchronous:
  - rx shift register, tx shift register, bit counter and result register clear to 0.
  - SPI_POCI=0; status word = 0.
- Synchronize SPI_CLK, SPI_CS and SPI_PICO through SYNC_STAGES flops. Detect edges in the sys_clock domain.
- RX path:
  - While CS low, each SCLK rising edge shifts PICO into rx_sr[0] (left shift) and increments a 7-bit bit count.
  - CS falling edge clears the bit count.
- TX path:
  - On CS falling edge, SPI_POCI = tx_sr[63].
  - Each SCLK falling edge shifts tx_sr left and drives the new MSB.
  - POCI must update within SYNC_STAGES+2 cycles of the physical falling edge.
- Frame end (synchronized CS rising edge):
  - Bit count == 64: A = rx_sr[63:32], B = rx_sr[31:0]. Sample {opcode2,opcode1}, compute, and load tx_sr = {status, result} no later than 6 sys_clock cycles after the physical CS rise.
  - Bit count != 64 (short or long frame): discard the frame; tx_sr and status are unchanged.
- Before the first valid frame, the block returns all zeros.
- Status word: bit0 = valid (1 after any completed op), bit1 = invalid (NaN result), bit2 = overflow; bits 31:3 are 0.
- Opcodes {opcode2,opcode1}:
  - 00 A+B
  - 01 A-B
  - 10 min(A,B)
  - 11 max(A,B)
- Arithmetic:
  - IEEE-754 binary32, round-to-nearest-even (guard/round/sticky).
  - Denormal inputs are flushed to ±0; denormal results are flushed to +0.
  - Exact-zero sum gives +0.
  - Any NaN input, or Inf-Inf, gives 0x7FC00000 with invalid=1.
  - Finite overflow gives signed Inf with overflow=1.
  - Inf op finite gives Inf.
  - min/max: compare as sign-magnitude values, -0 < +0; if either input is NaN, result 0x7FC00000.
- The result may be computed in one combinational cycle or pipelined, provided the 6-cycle deadline holds.
- Reset mid-frame aborts the transaction; the following frame is treated as a fresh first frame.
- Opcode pins must be stable from CS rise to load; changes while CS is low have no effect.

Decomposition:
- Shared package system_top_pkg:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MIN=2'b10, OP_MAX=2'b11
  - QNAN=32'h7FC00000
  - FRAME_W, DATA_W
  - status bit indices
- One sub-module, fp32_alu: combinational/pipelined add/sub/min/max with outputs result, invalid, overflow.
- SPI shifting, synchronizers and frame control stay in system_top.

Test Plan:
- Op 00; frame 0x430F8F5C_C2AEDFBE (143.56, -87.437) sent twice -> second rx frame = 0x00000001_42607DF4 (56.123); the first rx frame is all zeros after reset.
- Op 01; same operands sent twice -> second rx lower word 0x4366FF3B (230.997); 0x3F800000 - 0x3F800000 -> 0x00000000.
- Op 00; 0x3F800000 + 0x3F800000 -> 0x40000000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with status 0x00000005; 0x7FC00000 + 0x3F800000 -> 0x7FC00000 with status 0x00000003.
- Op 10/11; 0xBF800000 vs 0x40000000 -> min 0xBF800000, max 0x40000000.
- 40-bit truncated frame after a valid 1+1 frame -> next rx still returns the 1+1 result (0x00000001_40000000).
- Reset pulsed low mid-frame -> SPI_POCI=0 immediately; next frame returns all zeros; subsequent full frame computes normally.

Source files
------------

// File: rtl/system_top_pkg.sv
// Shared widths, opcodes and status layout for the SPI floating-point ALU.
package system_top_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FRAME_W     = 2 * DATA_W;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BIT_CNT_W   = 7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    localparam int unsigned ST_VALID    = 0;
    localparam int unsigned ST_INVALID  = 1;
    localparam int unsigned ST_OVERFLOW = 2;

    // Word order of the frame shifted back to the master, MSB first.
    typedef struct packed {
        logic [DATA_W-1:0] status;
        logic [DATA_W-1:0] result;
    } tx_frame_t;

endpackage

// File: rtl/fp32_alu.sv
// Binary32 add/sub/min/max; combinational datapath, one output register stage.
module fp32_alu
    import system_top_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              invalid,
    output logic              overflow,
    output logic              done
);

    logic              sa, sb, sbe;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]       ma, mb;
    logic [DATA_W-1:0] af, bf;

    logic              a_big, a_lt_b;
    logic              big_s, small_s;
    logic [7:0]        big_e, small_e, diff;
    logic [23:0]       big_m, small_m;
    logic [4:0]        dsh, lz;
    logic [55:0]       sh;
    logic [26:0]       big_al, small_al, norm;
    logic [27:0]       sum;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic [DATA_W-1:0] add_res, res_c;
    logic              add_ovf, inv_c, ovf_c;

    // Field unpacking with denormal inputs flushed to signed zero.
    always_comb begin
        sa     = a[31];
        sb     = b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        ma     = a_zero ? 24'd0 : {1'b1, fa};
        mb     = b_zero ? 24'd0 : {1'b1, fb};
        af     = a_zero ? {sa, 31'd0} : a;
        bf     = b_zero ? {sb, 31'd0} : b;
    end

    // Aligned add/subtract with guard/round/sticky and round-to-nearest-even.
    always_comb begin
        sbe      = (op == OP_SUB) ? ~sb : sb;
        a_big    = {ea, ma} >= {eb, mb};
        big_s    = a_big ? sa : sbe;
        big_e    = a_big ? ea : eb;
        big_m    = a_big ? ma : mb;
        small_s  = a_big ? sbe : sa;
        small_e  = a_big ? eb : ea;
        small_m  = a_big ? mb : ma;
        diff     = big_e - small_e;
        dsh      = (diff > 8'd31) ? 5'd31 : diff[4:0];
        sh       = {small_m, 32'd0} >> dsh;
        small_al = {sh[55:30], |sh[29:0]};
        big_al   = {big_m, 3'b000};
        if (big_s == small_s) begin
            sum = {1'b0, big_al} + {1'b0, small_al};
        end else begin
            sum = {1'b0, big_al} - {1'b0, small_al};
        end
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) begin
                lz = 5'(26 - i);
            end
        end
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed(10'(big_e)) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed(10'(big_e)) - $signed(10'(lz));
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + 25'(round_up);
        if (mant_r[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end else begin
            exp_r = exp_n;
            frac  = mant_r[22:0];
        end
        add_res = '0;
        add_ovf = 1'b0;
        if (sum == 28'd0) begin
            add_res = '0;
        end else if (exp_r >= 10'sd255) begin
            add_res = {big_s, 8'hFF, 23'd0};
            add_ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            add_res = '0;
        end else begin
            add_res = {big_s, exp_r[7:0], frac};
        end
    end

    // Operation select, special operands and sign-magnitude ordering.
    always_comb begin
        res_c = '0;
        inv_c = 1'b0;
        ovf_c = 1'b0;
        if (sa != sb) begin
            a_lt_b = sa;
        end else if (!sa) begin
            a_lt_b = af[30:0] < bf[30:0];
        end else begin
            a_lt_b = af[30:0] > bf[30:0];
        end
        if (a_nan || b_nan) begin
            res_c = QNAN;
            inv_c = 1'b1;
        end else if (op == OP_MIN) begin
            res_c = a_lt_b ? af : bf;
        end else if (op == OP_MAX) begin
            res_c = a_lt_b ? bf : af;
        end else if (a_inf && b_inf && (sa != sbe)) begin
            res_c = QNAN;
            inv_c = 1'b1;
        end else if (a_inf) begin
            res_c = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res_c = {sbe, 8'hFF, 23'd0};
        end else begin
            res_c = add_res;
            ovf_c = add_ovf;
        end
    end

    // Capture the result on start; done pulses the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result   <= res_c;
                invalid  <= inv_c;
                overflow <= ovf_c;
            end
        end
    end

endmodule

// File: rtl/system_top.sv
// SPI mode-0 slave front end feeding a binary32 ALU; all logic on sys_clock.
module system_top
    import system_top_pkg::*;
(
    input  logic sys_clock,
    input  logic reset,
    input  logic SPI_CLK,
    input  logic SPI_CS,
    input  logic SPI_PICO,
    output logic SPI_POCI,
    input  logic opcode1,
    input  logic opcode2,
    input  logic opcode3
);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, pico_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s_c, cs_s_c, pico_s_c;
    logic                   sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

    logic [FRAME_W-1:0]     rx_sr;
    logic [FRAME_W-1:0]     tx_sr;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    tx_frame_t              out_frame;

    logic                   alu_start_c;
    logic [DATA_W-1:0]      alu_result;
    logic                   alu_invalid, alu_overflow, alu_done;
    logic [DATA_W-1:0]      status_c;
    logic                   unused_c;

    assign unused_c = opcode3;

    // Synchronizers for the asynchronous SPI pins plus edge-detect history.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            pico_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            pico_sync <= {pico_sync[SYNC_STAGES-2:0], SPI_PICO};
            sclk_q    <= sclk_s_c;
            cs_q      <= cs_s_c;
        end
    end

    // Edge strobes; SCLK edges only count while the slave is selected.
    always_comb begin
        sclk_s_c    = sclk_sync[SYNC_STAGES-1];
        cs_s_c      = cs_sync[SYNC_STAGES-1];
        pico_s_c    = pico_sync[SYNC_STAGES-1];
        sclk_rise_c = sclk_s_c & ~sclk_q & ~cs_s_c;
        sclk_fall_c = ~sclk_s_c & sclk_q & ~cs_s_c;
        cs_fall_c   = ~cs_s_c & cs_q;
        cs_rise_c   = cs_s_c & ~cs_q;
        alu_start_c = cs_rise_c && (bit_cnt == BIT_CNT_W'(FRAME_W));
    end

    // Receive shifter; the counter saturates so over-long frames never look complete.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (cs_fall_c) begin
            bit_cnt <= '0;
        end else if (sclk_rise_c) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], pico_s_c};
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    fp32_alu u_alu (
        .clk      (sys_clock),
        .rst_n    (reset),
        .start    (alu_start_c),
        .op       ({opcode2, opcode1}),
        .a        (rx_sr[FRAME_W-1:DATA_W]),
        .b        (rx_sr[DATA_W-1:0]),
        .result   (alu_result),
        .invalid  (alu_invalid),
        .overflow (alu_overflow),
        .done     (alu_done)
    );

    // Status word assembled from the ALU flags.
    always_comb begin
        status_c              = '0;
        status_c[ST_VALID]    = 1'b1;
        status_c[ST_INVALID]  = alu_invalid;
        status_c[ST_OVERFLOW] = alu_overflow;
    end

    // Held response frame; discarded frames leave it untouched.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            out_frame <= '0;
        end else if (alu_done) begin
            out_frame.status <= status_c;
            out_frame.result <= alu_result;
        end
    end

    // Transmit shifter: reloaded from the held frame at each CS fall.
    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            tx_sr    <= '0;
            SPI_POCI <= 1'b0;
        end else if (cs_fall_c) begin
            tx_sr    <= out_frame;
            SPI_POCI <= out_frame.status[DATA_W-1];
        end else if (sclk_fall_c) begin
            tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
            SPI_POCI <= tx_sr[FRAME_W-2];
        end
    end

endmodule

// File: tb/tb_system_top.sv
// Scoreboard bench: each frame's response is checked on the following transfer.
module tb_system_top;
    import system_top_pkg::*;

    localparam int HALF = 50;

    logic clk;
    logic rst_n;
    logic sclk, cs, pico, poci;
    logic op1, op2, op3;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    system_top dut (
        .sys_clock (clk),
        .reset     (rst_n),
        .SPI_CLK   (sclk),
        .SPI_CS    (cs),
        .SPI_PICO  (pico),
        .SPI_POCI  (poci),
        .opcode1   (op1),
        .opcode2   (op2),
        .opcode3   (op3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One SPI transfer of nbits; compares the returned bits with the scoreboard head.
    task automatic xfer(input string name, input logic [63:0] tx, input int nbits,
                        input logic [1:0] op, input bit push, input logic [63:0] nxt);
        logic [63:0] rx, mask, expv;
        rx = '0;
        {op2, op1} = op;
        cs = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            pico = tx[63-i];
            #HALF;
            sclk = 1'b1;
            rx[63-i] = poci;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        cs = 1'b1;
        #200;
        mask = '1;
        mask = mask << (64 - nbits);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, scoreboard had no entry", name, rx & mask);
        end else begin
            if (nbits == 64) expv = exp_q.pop_front();
            else             expv = exp_q[0];
            if ((rx & mask) !== (expv & mask)) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, rx & mask, expv & mask);
            end
        end
        if (push) exp_q.push_back(nxt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs = 1'b1; sclk = 1'b0; pico = 1'b0;
        op1 = 1'b0; op2 = 1'b0; op3 = 1'b0;
        #20;
        checks++;
        if (poci !== 1'b0) begin
            errors++;
            $display("FAIL reset_poci: got %b expected 0", poci);
        end
        #30;
        rst_n = 1'b1;
        #40;
        checks++;
        if (poci !== 1'b0) begin
            errors++;
            $display("FAIL idle_poci: got %b expected 0", poci);
        end
        exp_q.delete();
        exp_q.push_back(64'h0);
    endtask

    task automatic test_add();
        xfer("add_first", 64'h430F8F5C_C2AEDFBE, 64, OP_ADD, 1, 64'h00000001_42607DF4);
        xfer("add_second", 64'h430F8F5C_C2AEDFBE, 64, OP_ADD, 1, 64'h00000001_42607DF4);
    endtask

    task automatic test_sub();
        xfer("sub_first", 64'h430F8F5C_C2AEDFBE, 64, OP_SUB, 1, 64'h00000001_4366FF3B);
        xfer("sub_second", 64'h430F8F5C_C2AEDFBE, 64, OP_SUB, 1, 64'h00000001_4366FF3B);
        xfer("sub_one_one", 64'h3F800000_3F800000, 64, OP_SUB, 1, 64'h00000001_00000000);
    endtask

    task automatic test_add_special();
        xfer("add_one_one", 64'h3F800000_3F800000, 64, OP_ADD, 1, 64'h00000001_40000000);
        xfer("add_overflow", 64'h7F7FFFFF_7F7FFFFF, 64, OP_ADD, 1, 64'h00000005_7F800000);
        xfer("add_nan", 64'h7FC00000_3F800000, 64, OP_ADD, 1, 64'h00000003_7FC00000);
    endtask

    task automatic test_min_max();
        xfer("min", 64'hBF800000_40000000, 64, OP_MIN, 1, 64'h00000001_BF800000);
        xfer("max", 64'hBF800000_40000000, 64, OP_MAX, 1, 64'h00000001_40000000);
    endtask

    task automatic test_truncated();
        xfer("pre_trunc", 64'h3F800000_3F800000, 64, OP_ADD, 1, 64'h00000001_40000000);
        xfer("trunc40", 64'h7F7FFFFF_7F7FFFFF, 40, OP_ADD, 0, 64'h0);
        xfer("after_trunc", 64'h3F800000_3F800000, 64, OP_SUB, 1, 64'h00000001_00000000);
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] held;
        held = exp_q[0];
        op1 = 1'b0; op2 = 1'b0;
        cs = 1'b0;
        #60;
        for (int i = 0; i < 31; i++) begin
            pico = 1'b1;
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        checks++;
        if (poci !== held[32]) begin
            errors++;
            $display("FAIL mid_frame_poci: got %b expected %b", poci, held[32]);
        end
        rst_n = 1'b0;
        #10;
        checks++;
        if (poci !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_poci: got %b expected 0", poci);
        end
        sclk = 1'b0; cs = 1'b1; pico = 1'b0;
        #50;
        rst_n = 1'b1;
        #100;
        exp_q.delete();
        exp_q.push_back(64'h0);
        xfer("post_reset_first", 64'h3F800000_3F800000, 64, OP_ADD, 1, 64'h00000001_40000000);
        xfer("post_reset_second", 64'hBF800000_40000000, 64, OP_MAX, 1, 64'h00000001_40000000);
        xfer("drain", 64'h0, 64, OP_ADD, 0, 64'h0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_add_special();
        test_min_max();
        test_truncated();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
